mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register; consumes the EX/MEM register outputs (M_*).
//  Performs data-memory access: word and halfword (lh/sh) loads and stores; jal-style PC+8 result select.
//  Registers everything the WB mux needs. Also provides a combinational MEM-stage forwarding value for EX.
//  Sticky misalignment flag and saturating load/store counters support debug and verification.
// PARAMETERS
//  data_size   32  datapath width (bits)
//  pc_size     18  PC width; PC+8 is zero-extended to data_size
//  addr_width  10  word-index width of data memory (depth = 2**addr_width words)
//  cnt_width   16  width of load/store access counters
// PORTS
//  clk            in   1           clock; all state updates on negedge clk (pipeline-wide convention)
//  rst            in   1           reset, synchronous, active-high
//  M_MemtoReg     in   1           WB: select memory data
//  M_RegWrite     in   1           WB: register write enable
//  M_MemWrite     in   1           store request (sw, or sh when M_sh=1)
//  M_lh           in   1           load is halfword, sign-extended
//  M_sh           in   1           store is halfword
//  M_ALU_PC       in   1           result is PC+8 (link) instead of ALU result
//  M_ALU_result   in   data_size   ALU result / byte address
//  M_Rt_data      in   data_size   store data
//  M_PCplus8      in   pc_size     link address
//  M_WR_out       in   5           destination register
//  M_fwd_data     out  data_size   comb: M_ALU_PC ? zext(M_PCplus8) : M_ALU_result
//  WB_MemtoReg    out  1           registered M_MemtoReg
//  WB_RegWrite    out  1           registered M_RegWrite
//  WB_DM_data     out  data_size   registered load data (word or sign-extended half)
//  WB_ALU_result  out  data_size   registered M_fwd_data
//  WB_WR_out      out  5           registered M_WR_out
//  misalign       out  1           sticky: a misaligned access was seen since reset
//  load_cnt       out  cnt_width   loads completed (M_MemtoReg=1 and aligned), saturating
//  store_cnt      out  cnt_width   stores committed, saturating
// BEHAVIOUR
//  - Reset (negedge clk with rst=1): all WB_* outputs, misalign, load_cnt, store_cnt <= 0; no memory write.
//    Memory contents are NOT cleared by rst. rst mid-stream drops the in-flight MEM instruction.
//  - Address: byte addr = M_ALU_result; word index = addr[addr_width+1:2]; upper bits are ignored (wrap).
//  - Byte order is big-endian: addr[1]=0 selects bits[31:16], addr[1]=1 selects bits[15:0].
//  - Read is combinational from the array.
//  - Load data: M_lh ? sext(selected half) : word. Captured into WB_DM_data at the same edge -> 1-cycle latency.
//  - Store, at negedge when M_MemWrite & aligned & !rst:
//    - sw writes the full word.
//    - sh writes M_Rt_data[15:0] into the selected half only; the other half is preserved.
//  - Alignment rules:
//    - word access requires addr[1:0]=0; half access requires addr[0]=0.
//    - Misaligned store: suppressed.
//    - Misaligned load: WB_DM_data <= 0.
//    - Either case sets misalign=1 (held until rst).
//  - Alignment check applies only when an access occurs: M_MemWrite or M_MemtoReg.
//  - Store followed by load of the same address in the next cycle returns the new data (write precedes read).
//  - M_MemWrite=1 with M_MemtoReg=1 is illegal; the store is performed and load data is undefined.
//  - Counters increment by 1 per qualifying access and hold at 2**cnt_width-1.
//  - Pass-through fields are registered unchanged: 1-cycle latency, no stall/flush inputs.
//  - M_lh/M_sh are ignored when no access occurs.
// STRUCTURE
//  - Shared include mips_defs.vh: data_size/pc_size defaults, HALF_HI/HALF_LO lane select constants.
//  - Sub-module dm_array: 2**addr_width x data_size memory.
//    - Comb read; negedge write with 2-bit half-word enables {hi,lo}.
//  - Top level holds: lane/sign-extend logic, alignment check, MEM/WB register, counters.
// TESTING
//  1. rst=1 for 2 cycles after arbitrary inputs -> all WB_*, misalign, counters = 0.
//  2. sw 0xDEADBEEF @0x10; lw @0x10 next cycle -> WB_DM_data=0xDEADBEEF one cycle later.
//     store_cnt=1, load_cnt=1.
//  3. sh Rt=0x1234CAFE @0x12 over 0xDEADBEEF -> word=0xDEADCAFE.
//     lh @0x12 -> 0xFFFFCAFE; lh @0x10 -> 0xFFFFDEAD.
//  4. sw @0x21 -> memory unchanged, misalign=1 and held.
//     Later aligned accesses still work; misalign clears only on rst.
//  5. M_ALU_PC=1, M_PCplus8=0x00108, M_ALU_result=0x55 -> M_fwd_data=0x108 same cycle.
//     WB_ALU_result=0x108 next edge.
//  6. Preload counter near max (cnt_width=2 build), issue 5 stores -> store_cnt saturates at 3.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage and MEM/WB register.
// Provides the default datapath widths, the big-endian half-word lane
// select encodings (value of addr[1]) and the half-word helpers.
package mem_wb_stage_pkg;

    localparam int DATA_SIZE = 32;
    localparam int PC_SIZE   = 18;

    // addr[1] value that selects each 16-bit lane (big-endian)
    localparam logic HALF_HI = 1'b0;   // bits [31:16]
    localparam logic HALF_LO = 1'b1;   // bits [15:0]

    // {hi,lo} write enables
    typedef enum logic [1:0] {
        WE_NONE = 2'b00,
        WE_LO   = 2'b01,
        WE_HI   = 2'b10,
        WE_WORD = 2'b11
    } half_we_e;

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_stage_dm_array.sv
// Data memory: 2**addr_width words of data_size bits.
// Read is combinational; write happens on the falling clock edge with
// independent enables for the upper and lower half-words.
// Ports:
//   i_clk    clock (writes on negedge)
//   i_we     {hi,lo} half-word write enables
//   i_addr   word index
//   i_wdata  write data (both lanes presented, enables pick which land)
//   o_rdata  combinational read data
module dm_array
    import mem_wb_stage_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int addr_width = 10
) (
    input  logic                  i_clk,
    input  logic [1:0]            i_we,
    input  logic [addr_width-1:0] i_addr,
    input  logic [data_size-1:0]  i_wdata,
    output logic [data_size-1:0]  o_rdata
);
    localparam int HALF = data_size / 2;

    logic [data_size-1:0] r_mem [2**addr_width];

    always_ff @(negedge i_clk) begin
        if (i_we[1]) r_mem[i_addr][data_size-1:HALF] <= i_wdata[data_size-1:HALF];
        if (i_we[0]) r_mem[i_addr][HALF-1:0]         <= i_wdata[HALF-1:0];
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register.
// Performs word/half-word loads and stores against dm_array, selects the
// PC+8 link value for jal-style ops, and registers everything WB needs.
// Also keeps a sticky misalignment flag and saturating access counters.
// Ports:
//   clk, rst                  clock (state on negedge), sync active-high reset
//   M_*                       EX/MEM register outputs (controls, address, data)
//   M_fwd_data                comb MEM-stage forwarding value for EX
//   WB_*                      registered MEM/WB outputs
//   misalign                  sticky misaligned-access flag
//   load_cnt, store_cnt       saturating counts of aligned loads / stores
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int pc_size    = PC_SIZE,
    parameter int addr_width = 10,
    parameter int cnt_width  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_MemtoReg,
    input  logic                 M_RegWrite,
    input  logic                 M_MemWrite,
    input  logic                 M_lh,
    input  logic                 M_sh,
    input  logic                 M_ALU_PC,
    input  logic [data_size-1:0] M_ALU_result,
    input  logic [data_size-1:0] M_Rt_data,
    input  logic [pc_size-1:0]   M_PCplus8,
    input  logic [4:0]           M_WR_out,
    output logic [data_size-1:0] M_fwd_data,
    output logic                 WB_MemtoReg,
    output logic                 WB_RegWrite,
    output logic [data_size-1:0] WB_DM_data,
    output logic [data_size-1:0] WB_ALU_result,
    output logic [4:0]           WB_WR_out,
    output logic                 misalign,
    output logic [cnt_width-1:0] load_cnt,
    output logic [cnt_width-1:0] store_cnt
);
    localparam int HALF = data_size / 2;

    logic                  w_access;
    logic                  w_half;
    logic                  w_misal;
    logic                  w_store_ok;
    logic                  w_load_ok;
    logic [1:0]            w_we;
    logic [data_size-1:0]  w_wdata;
    logic [data_size-1:0]  w_rdata;
    logic [HALF-1:0]       w_lane;
    logic [data_size-1:0]  w_load_data;
    logic [data_size-1:0]  w_dm_next;
    logic                  w_unused_addr_hi;

    // Upper address bits are intentionally ignored: the array wraps.
    assign w_unused_addr_hi = ^M_ALU_result[data_size-1:addr_width+2];

    assign M_fwd_data = M_ALU_PC ? {{(data_size-pc_size){1'b0}}, M_PCplus8} : M_ALU_result;

    // Access width comes from the store flag for stores, the load flag for loads.
    assign w_access   = M_MemWrite | M_MemtoReg;
    assign w_half     = M_MemWrite ? M_sh : M_lh;
    assign w_misal    = w_access & (w_half ? M_ALU_result[0] : (|M_ALU_result[1:0]));
    assign w_store_ok = M_MemWrite & ~w_misal & ~rst;
    assign w_load_ok  = M_MemtoReg & ~w_misal;

    always_comb begin
        w_we = WE_NONE;
        if (w_store_ok) begin
            if (!M_sh)                          w_we = WE_WORD;
            else if (M_ALU_result[1] == HALF_HI) w_we = WE_HI;
            else                                w_we = WE_LO;
        end
    end

    // For sh the half is replicated into both lanes; the enables pick one.
    assign w_wdata = M_sh ? {M_Rt_data[HALF-1:0], M_Rt_data[HALF-1:0]} : M_Rt_data;

    dm_array #(
        .data_size  (data_size),
        .addr_width (addr_width)
    ) u_dm (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  (M_ALU_result[addr_width+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_lane      = (M_ALU_result[1] == HALF_HI) ? w_rdata[data_size-1:HALF] : w_rdata[HALF-1:0];
    assign w_load_data = M_lh ? {{HALF{w_lane[HALF-1]}}, w_lane} : w_rdata;
    assign w_dm_next   = (M_MemtoReg && w_misal) ? '0 : w_load_data;

    always_ff @(negedge clk) begin
        if (rst) begin
            WB_MemtoReg   <= 1'b0;
            WB_RegWrite   <= 1'b0;
            WB_DM_data    <= '0;
            WB_ALU_result <= '0;
            WB_WR_out     <= '0;
            misalign      <= 1'b0;
            load_cnt      <= '0;
            store_cnt     <= '0;
        end else begin
            WB_MemtoReg   <= M_MemtoReg;
            WB_RegWrite   <= M_RegWrite;
            WB_DM_data    <= w_dm_next;
            WB_ALU_result <= M_fwd_data;
            WB_WR_out     <= M_WR_out;
            if (w_misal)                     misalign  <= 1'b1;
            if (w_load_ok  && ~&load_cnt)    load_cnt  <= load_cnt + 1'b1;
            if (w_store_ok && ~&store_cnt)   store_cnt <= store_cnt + 1'b1;
        end
    end

endmodule
